// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// A clear sequencer walks every entry after reset or flush before lookups may hit.
module btb_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        ready,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        dbg_state
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] CLR_LAST = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] clr_idx_q, clr_idx_d;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [31:0]           target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx, up_idx, wr_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  lk_hit, up_hit;
  logic [1:0]            up_ctr;
  logic                  wr_en, wr_full, wr_valid;
  logic [1:0]            wr_ctr;

  // Instruction-alignment bits play no part in indexing or tagging.
  logic unused_align;
  assign unused_align = ^{pc[1:0], upd_pc[1:0]};

  assign lk_idx = pc[INDEX_BITS+1:2];
  assign lk_tag = pc[31:INDEX_BITS+2];
  assign up_idx = upd_pc[INDEX_BITS+1:2];
  assign up_tag = upd_pc[31:INDEX_BITS+2];
  assign up_ctr = ctr_q[up_idx];

  assign lk_hit      = (state_q == ST_RUN) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? target_q[lk_idx] : (pc + 32'd4);
  assign ready       = (state_q == ST_RUN);
  assign dbg_state   = state_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_en     = 1'b0;
    wr_full   = 1'b0;
    wr_valid  = 1'b0;
    wr_idx    = clr_idx_q;
    wr_ctr    = 2'b01;
    case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        if (flush) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == CLR_LAST) begin
          state_d   = ST_RUN;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        // flush takes priority; a same-cycle update is discarded.
        if (flush) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end else if (upd_valid) begin
          wr_idx = up_idx;
          if (up_hit) begin
            wr_en    = 1'b1;
            wr_valid = 1'b1;
            wr_full  = upd_taken;
            if (upd_taken) wr_ctr = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
            else           wr_ctr = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
          end else if (upd_taken) begin
            wr_en    = 1'b1;
            wr_valid = 1'b1;
            wr_full  = 1'b1;
            wr_ctr   = 2'b10;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Table storage has no reset; the clear walk invalidates it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      ctr_q[wr_idx]   <= wr_ctr;
      if (wr_full) begin
        tag_q[wr_idx]    <= up_tag;
        target_q[wr_idx] <= upd_target;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: a reference table model feeds an
// expected queue that is compared against the lookup outputs every cycle.
module tb_btb_predictor;

  localparam int W = 34;  // {ready, pred_taken, pred_target}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ready;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_obs;

  // Reference table
  bit          m_run = 1'b0;
  int          m_clr = 0;
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_target[16];
  logic [1:0]  m_ctr   [16];

  btb_predictor #(.INDEX_BITS(4)) dut (
    .clk         (clk),
    .reset       (rst),
    .flush       (flush),
    .pc          (pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .ready       (ready),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_out(input logic [31:0] a);
    logic [3:0] i;
    logic       tk;
    i  = a[5:2];
    tk = m_run && m_valid[i] && (m_tag[i] == a[31:6]) && m_ctr[i][1];
    return {m_run, tk, tk ? m_target[i] : a + 32'd4};
  endfunction

  task automatic model_step();
    logic [3:0] i;
    i = upd_pc[5:2];
    if (rst) begin
      m_run = 1'b0;
      m_clr = 0;
    end else if (!m_run) begin
      m_valid[m_clr] = 1'b0;
      m_ctr[m_clr]   = 2'b01;
      if (flush)            m_clr = 0;
      else if (m_clr == 15) begin m_run = 1'b1; m_clr = 0; end
      else                  m_clr++;
    end else if (flush) begin
      m_run = 1'b0;
      m_clr = 0;
    end else if (upd_valid) begin
      if (m_valid[i] && m_tag[i] == upd_pc[31:6]) begin
        if (upd_taken) begin
          m_ctr[i]    = (m_ctr[i] == 2'b11) ? 2'b11 : m_ctr[i] + 2'd1;
          m_target[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] == 2'b00) ? 2'b00 : m_ctr[i] - 2'd1;
        end
      end else if (upd_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = upd_pc[31:6];
        m_target[i] = upd_target;
        m_ctr[i]    = 2'b10;
      end
    end
  endtask

  // One clock: sample mid-cycle against the model, then advance both at posedge.
  task automatic cyc();
    @(negedge clk);
    exp_q.push_back(model_out(pc));
    last_obs = {ready, pred_taken, pred_target};
    check_eq("lookup", last_obs, exp_q.pop_front());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_upd(input logic v, input logic [31:0] a, input logic tk, input logic [31:0] tgt);
    upd_valid  = v;
    upd_pc     = a;
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  task automatic lookup(input string tag, input logic [31:0] a, input logic [W-1:0] exp);
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0);
    pc = a;
    cyc();
    check_eq(tag, last_obs, exp);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_run = 1'b0;
    m_clr = 0;
    cyc();
    check_eq("reset_out", last_obs, {1'b0, 1'b0, pc + 32'd4});
    cyc();
    rst = 1'b0;
  endtask

  // Counts cycles with ready low; bounded so a stuck FSM still ends the run.
  task automatic count_clear(input string tag);
    int n;
    n = 0;
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0);
    flush = 1'b0;
    pc = 32'h100;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (k == 0) check_eq("clear_pred", last_obs, {1'b0, 1'b0, 32'h104});
      if (last_obs[W-1]) break;
      n++;
    end
    check_eq(tag, W'(n), W'(16));
  endtask

  logic [31:0] pool [8];

  initial begin
    pool = '{32'h40, 32'h440, 32'h44, 32'h80, 32'h1000, 32'h1040, 32'h7c, 32'hfffffffc};

    // 1. reset and first clear walk
    do_reset();
    count_clear("clear_len_reset");

    // 2. allocate
    pc = 32'h0;
    drive_upd(1'b1, 32'h40, 1'b1, 32'h80);
    cyc();
    lookup("alloc_hit", 32'h40, {1'b1, 1'b1, 32'h80});

    // 3. counter training
    pc = 32'h0;
    drive_upd(1'b1, 32'h40, 1'b0, 32'h0);
    cyc();
    cyc();
    lookup("ctr_down", 32'h40, {1'b1, 1'b0, 32'h44});
    drive_upd(1'b1, 32'h40, 1'b1, 32'h80);
    repeat (4) cyc();
    drive_upd(1'b1, 32'h40, 1'b0, 32'h0);
    cyc();
    lookup("ctr_sat", 32'h40, {1'b1, 1'b1, 32'h80});

    // 4. alias replacement at the same index
    drive_upd(1'b1, 32'h440, 1'b1, 32'h900);
    cyc();
    lookup("alias_old", 32'h40, {1'b1, 1'b0, 32'h44});
    lookup("alias_new", 32'h442, {1'b1, 1'b1, 32'h900});

    // 5. same-cycle lookup and update see the old entry
    pc = 32'h440;
    drive_upd(1'b1, 32'h440, 1'b0, 32'h0);
    cyc();
    check_eq("no_bypass", last_obs, {1'b1, 1'b1, 32'h900});
    lookup("after_upd", 32'h440, {1'b1, 1'b0, 32'h444});

    // 6. flush with simultaneous update, then restarts mid-clear
    drive_upd(1'b1, 32'h40, 1'b1, 32'h80);
    cyc();
    flush = 1'b1;
    drive_upd(1'b1, 32'h200, 1'b1, 32'h300);
    cyc();
    count_clear("clear_len_flush");
    lookup("flush_miss_a", 32'h40, {1'b1, 1'b0, 32'h44});
    lookup("flush_miss_b", 32'h200, {1'b1, 1'b0, 32'h204});

    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (5) cyc();
    flush = 1'b1;
    drive_upd(1'b1, 32'h200, 1'b1, 32'h300);
    cyc();
    count_clear("clear_len_reflush");

    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (7) cyc();
    do_reset();
    count_clear("clear_len_rereset");

    // 7. random traffic against the model
    for (int k = 0; k < 400; k++) begin
      pc    = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      flush = ($urandom_range(0, 59) == 0);
      drive_upd($urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
                $urandom_range(0, 2) != 0, 32'($urandom_range(0, 1023)) << 2);
      cyc();
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
